sysid_check_ctrl: RTL and testbench

Sequencer and arbiter in front of the system-ID slave (word 0 = system ID, word 1 = build timestamp).
- After `start`, it reads both words, compares them against build-time expected values and retries on mismatch.
- It reports pass/fail to the boot/reset logic.
- When no check is running, it forwards host (Avalon-MM master) reads to the same slave, so the CPU and the checker share one sysid instance.

---
 rtl/sysid_check_pkg.sv | 17 +
 rtl/sysid_check_ctrl_if.sv | 20 ++
 rtl/sysid_read_timer.sv | 25 ++
 rtl/sysid_check_ctrl.sv | 157 +++++++++++++++
 tb/tb_sysid_check_ctrl.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sysid_check_pkg.sv
// Shared types and constants for the system-ID checker and its host arbiter.
package sysid_check_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ID,
    ST_RD_TS,
    ST_EVAL,
    ST_HOST
  } state_t;

  localparam logic        SYSID_WORD_ID       = 1'b0;
  localparam logic        SYSID_WORD_TS       = 1'b1;
  localparam logic [31:0] DEFAULT_EXPECTED_ID = 32'd0;
  localparam logic [31:0] DEFAULT_EXPECTED_TS = 32'd1362613388;

endpackage

// File: rtl/sysid_check_ctrl_if.sv
// Avalon-MM host read channel shared between the CPU and the sysid checker.
interface sysid_check_ctrl_if;

  logic        host_read;
  logic        host_address;
  logic        host_waitrequest;
  logic [31:0] host_readdata;
  logic        host_readdatavalid;

  modport master (
    output host_read, host_address,
    input  host_waitrequest, host_readdata, host_readdatavalid
  );

  modport slave (
    input  host_read, host_address,
    output host_waitrequest, host_readdata, host_readdatavalid
  );

endinterface

// File: rtl/sysid_read_timer.sv
// Hold counter: load with the read latency, expires on the last cycle of a read.
module sysid_read_timer #(
  parameter int unsigned READ_LATENCY = 0
) (
  input  logic clock,
  input  logic reset,
  input  logic i_load,
  output logic o_expire
);

  logic [1:0] r_cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt <= 2'd0;
    end else if (i_load) begin
      r_cnt <= 2'(READ_LATENCY);
    end else if (r_cnt != 2'd0) begin
      r_cnt <= r_cnt - 2'd1;
    end
  end

  assign o_expire = (r_cnt == 2'd0);

endmodule

// File: rtl/sysid_check_ctrl.sv
// Reads and verifies the sysid words after start, retrying on mismatch, and
// forwards host reads to the same slave whenever no check is running.
module sysid_check_ctrl
  import sysid_check_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID  = DEFAULT_EXPECTED_ID,
  parameter logic [31:0] EXPECTED_TS  = DEFAULT_EXPECTED_TS,
  parameter int unsigned READ_LATENCY = 0,
  parameter int unsigned MAX_RETRIES  = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  sysid_check_ctrl_if.slave host,
  output logic        sysid_address,
  input  logic [31:0] sysid_readdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        id_ok,
  output logic        ts_ok,
  output logic [3:0]  retry_count,
  output logic [31:0] captured_id,
  output logic [31:0] captured_ts
);

  state_t      r_state;
  logic        r_addr;
  logic [31:0] r_hdata;
  logic        r_hvalid;
  logic        r_host_cap;
  logic        r_done;
  logic        r_pass;
  logic        r_id_ok;
  logic        r_ts_ok;
  logic [3:0]  r_retry;
  logic [31:0] r_cap_id;
  logic [31:0] r_cap_ts;

  logic w_expire;
  logic w_load;
  logic w_id_match;
  logic w_ts_match;
  logic w_can_retry;

  function automatic logic [3:0] retry_inc(input logic [3:0] cnt);
    return (cnt < 4'(MAX_RETRIES)) ? cnt + 4'd1 : cnt;
  endfunction

  assign w_id_match  = (r_cap_id == EXPECTED_ID);
  assign w_ts_match  = (r_cap_ts == EXPECTED_TS);
  assign w_can_retry = (r_retry < 4'(MAX_RETRIES));

  // The timer is reloaded on every edge that enters RD_ID, RD_TS or HOST.
  assign w_load = ((r_state == ST_IDLE) && (start || host.host_read)) ||
                  ((r_state == ST_RD_ID) && w_expire) ||
                  ((r_state == ST_EVAL) && !(w_id_match && w_ts_match) && w_can_retry);

  sysid_read_timer #(.READ_LATENCY(READ_LATENCY)) u_timer (
    .clock    (clock),
    .reset    (reset),
    .i_load   (w_load),
    .o_expire (w_expire)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_addr     <= SYSID_WORD_ID;
      r_hdata    <= 32'd0;
      r_hvalid   <= 1'b0;
      r_host_cap <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_id_ok    <= 1'b0;
      r_ts_ok    <= 1'b0;
      r_retry    <= 4'd0;
      r_cap_id   <= 32'd0;
      r_cap_ts   <= 32'd0;
    end else begin
      r_done   <= 1'b0;
      r_hvalid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_RD_ID;
            r_addr  <= SYSID_WORD_ID;
            r_retry <= 4'd0;
            r_pass  <= 1'b0;
            r_id_ok <= 1'b0;
            r_ts_ok <= 1'b0;
          end else if (host.host_read) begin
            r_state    <= ST_HOST;
            r_addr     <= host.host_address;
            r_host_cap <= 1'b0;
          end
        end
        ST_RD_ID: begin
          if (w_expire) begin
            r_cap_id <= sysid_readdata;
            r_addr   <= SYSID_WORD_TS;
            r_state  <= ST_RD_TS;
          end
        end
        ST_RD_TS: begin
          if (w_expire) begin
            r_cap_ts <= sysid_readdata;
            r_state  <= ST_EVAL;
          end
        end
        ST_EVAL: begin
          r_id_ok <= w_id_match;
          r_ts_ok <= w_ts_match;
          if (w_id_match && w_ts_match) begin
            r_pass  <= 1'b1;
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
          end else if (w_can_retry) begin
            r_retry <= retry_inc(r_retry);
            r_addr  <= SYSID_WORD_ID;
            r_state <= ST_RD_ID;
          end else begin
            r_pass  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        ST_HOST: begin
          // Data is captured on the last hold cycle; the valid pulse follows one cycle later.
          if (r_host_cap) begin
            r_hvalid   <= 1'b1;
            r_host_cap <= 1'b0;
            r_state    <= ST_IDLE;
          end else if (w_expire) begin
            r_hdata    <= sysid_readdata;
            r_host_cap <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign host.host_waitrequest   = !((r_state == ST_IDLE) && !start);
  assign host.host_readdata      = r_hdata;
  assign host.host_readdatavalid = r_hvalid;
  assign sysid_address           = r_addr;
  assign busy                    = (r_state != ST_IDLE);
  assign done                    = r_done;
  assign pass                    = r_pass;
  assign id_ok                   = r_id_ok;
  assign ts_ok                   = r_ts_ok;
  assign retry_count             = r_retry;
  assign captured_id             = r_cap_id;
  assign captured_ts             = r_cap_ts;

endmodule

// File: tb/tb_sysid_check_ctrl.sv
// Bench for sysid_check_ctrl: three instances at read latencies 0, 1 and 2
// share one clock and reset; each has its own sysid slave model.
module tb_sysid_check_ctrl;

  localparam logic [31:0] EXP_ID = 32'd0;
  localparam logic [31:0] EXP_TS = 32'd1362613388;
  localparam int          MAXR   = 3;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic [2:0]        st, hr, ha, hw, hv, sa;
  logic [2:0]        busy_o, done_o, pass_o, idok_o, tsok_o;
  logic [2:0][31:0]  hd, w0, w1, cid, cts, rdata;
  logic [2:0][3:0]   rc;

  int n_chk = 0;
  int n_err = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    sysid_check_ctrl_if bus ();
    assign bus.host_read    = hr[g];
    assign bus.host_address = ha[g];
    assign hw[g]            = bus.host_waitrequest;
    assign hd[g]            = bus.host_readdata;
    assign hv[g]            = bus.host_readdatavalid;
    assign rdata[g]         = sa[g] ? w1[g] : w0[g];

    sysid_check_ctrl #(.READ_LATENCY(g)) u_dut (
      .clock          (clock),
      .reset          (reset),
      .start          (st[g]),
      .host           (bus),
      .sysid_address  (sa[g]),
      .sysid_readdata (rdata[g]),
      .busy           (busy_o[g]),
      .done           (done_o[g]),
      .pass           (pass_o[g]),
      .id_ok          (idok_o[g]),
      .ts_ok          (tsok_o[g]),
      .retry_count    (rc[g]),
      .captured_id    (cid[g]),
      .captured_ts    (cts[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference: attempt a compares (id,ts); first attempt sees id0, later ones idn.
  task automatic ref_check(input int L, input logic [31:0] id0, input logic [31:0] idn,
                           input logic [31:0] ts, output int lat, output logic p,
                           output logic io, output logic to, output logic [3:0] r,
                           output logic [31:0] last_id);
    int a;
    for (a = 0; a <= MAXR; a++) begin
      last_id = (a == 0) ? id0 : idn;
      io = (last_id == EXP_ID);
      to = (ts == EXP_TS);
      if (io && to) break;
    end
    if (a > MAXR) a = MAXR;
    p   = io && to;
    r   = 4'(a);
    lat = (a + 1) * (3 + 2 * L);
  endtask

  task automatic check_reset_state(input int g, input string tag);
    chk({tag, ".busy"},  32'(busy_o[g]), 32'd0);
    chk({tag, ".done"},  32'(done_o[g]), 32'd0);
    chk({tag, ".pass"},  32'(pass_o[g]), 32'd0);
    chk({tag, ".idok"},  32'(idok_o[g]), 32'd0);
    chk({tag, ".tsok"},  32'(tsok_o[g]), 32'd0);
    chk({tag, ".rc"},    32'(rc[g]),     32'd0);
    chk({tag, ".saddr"}, 32'(sa[g]),     32'd0);
    chk({tag, ".hdata"}, hd[g],          32'd0);
    chk({tag, ".hvalid"},32'(hv[g]),     32'd0);
    chk({tag, ".hwait"}, 32'(hw[g]),     32'd0);
    chk({tag, ".capid"}, cid[g],         32'd0);
    chk({tag, ".capts"}, cts[g],         32'd0);
  endtask

  // fix_at > 0: word 0 is replaced by fix_w0 after that many edges past start.
  task automatic run_check(input int g, input int fix_at, input logic [31:0] fix_w0,
                           input string tag);
    int lat_e, n;
    logic p_e, i_e, t_e;
    logic [3:0] r_e;
    logic [31:0] id_e, ts_e;
    ts_e = w1[g];
    ref_check(g, w0[g], (fix_at > 0) ? fix_w0 : w0[g], ts_e, lat_e, p_e, i_e, t_e, r_e, id_e);
    @(negedge clock);
    st[g] = 1'b1;
    @(posedge clock);
    #1 st[g] = 1'b0;
    chk({tag, ".busy"}, 32'(busy_o[g]), 32'd1);
    n = 0;
    while (n < 200) begin
      @(posedge clock);
      #1 n++;
      if (fix_at > 0 && n == fix_at) w0[g] = fix_w0;
      if (done_o[g]) break;
    end
    chk({tag, ".latency"}, 32'(n), 32'(lat_e));
    chk({tag, ".pass"},  32'(pass_o[g]), 32'(p_e));
    chk({tag, ".idok"},  32'(idok_o[g]), 32'(i_e));
    chk({tag, ".tsok"},  32'(tsok_o[g]), 32'(t_e));
    chk({tag, ".rc"},    32'(rc[g]),     32'(r_e));
    chk({tag, ".capid"}, cid[g],         id_e);
    chk({tag, ".capts"}, cts[g],         ts_e);
    @(posedge clock);
    #1 chk({tag, ".done_pulse"}, 32'(done_o[g]), 32'd0);
  endtask

  // Host read task; returns once readdatavalid is seen (or the budget expires).
  task automatic host_rd(input int g, input logic addr, input string tag);
    int n;
    logic [31:0] exp_d;
    exp_d = addr ? w1[g] : w0[g];
    @(negedge clock);
    hr[g] = 1'b1;
    ha[g] = addr;
    n = 0;
    while (hw[g] && n < 200) begin
      @(negedge clock);
      n++;
    end
    chk({tag, ".accept"}, 32'(hw[g]), 32'd0);
    @(posedge clock);
    #1 hr[g] = 1'b0;
    n = 0;
    while (n < 50) begin
      @(posedge clock);
      #1 n++;
      if (hv[g]) break;
    end
    chk({tag, ".latency"}, 32'(n), 32'(2 + g));
    chk({tag, ".data"}, hd[g], exp_d);
    @(posedge clock);
    #1 chk({tag, ".valid_pulse"}, 32'(hv[g]), 32'd0);
  endtask

  initial begin
    int n, g, mode, bad_w, hw_high_bad;
    st = '0; hr = '0; ha = '0;
    for (int i = 0; i < 3; i++) begin
      w0[i] = EXP_ID;
      w1[i] = EXP_TS;
    end
    repeat (2) @(posedge clock);
    #1;
    for (int i = 0; i < 3; i++) check_reset_state(i, $sformatf("reset%0d", i));
    @(negedge clock);
    reset = 1'b0;

    // Nominal check at L=0.
    run_check(0, 0, 32'd0, "nominal_L0");

    // Word 1 stuck at zero: retries exhausted.
    w1[0] = 32'd0;
    run_check(0, 0, 32'd0, "ts_stuck_L0");
    w1[0] = EXP_TS;

    // L=2, word 0 wrong on the first read only.
    w0[2] = 32'hDEAD_BEEF;
    run_check(2, 5, EXP_ID, "id_first_bad_L2");

    // Host reads at L=1.
    host_rd(1, 1'b1, "host_ts_L1");
    host_rd(1, 1'b0, "host_id_L1");

    // start and host_read together: check first, host read after done.
    @(negedge clock);
    st[0] = 1'b1; hr[0] = 1'b1; ha[0] = 1'b1;
    @(posedge clock);
    #1 st[0] = 1'b0;
    hw_high_bad = 0;
    n = 0;
    while (n < 50) begin
      if (!done_o[0] && !hw[0]) hw_high_bad++;
      @(posedge clock);
      #1 n++;
      if (done_o[0]) break;
    end
    chk("both.wait_during_check", 32'(hw_high_bad), 32'd0);
    chk("both.latency", 32'(n), 32'd3);
    chk("both.pass", 32'(pass_o[0]), 32'd1);
    chk("both.wait_after_done", 32'(hw[0]), 32'd0);
    @(posedge clock);
    #1 hr[0] = 1'b0;
    n = 0;
    while (n < 50) begin
      @(posedge clock);
      #1 n++;
      if (hv[0]) break;
    end
    chk("both.host_latency", 32'(n), 32'd2);
    chk("both.host_data", hd[0], EXP_TS);

    // Reset in the middle of RD_TS at L=1.
    @(negedge clock);
    st[1] = 1'b1;
    @(posedge clock);
    #1 st[1] = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    #1 check_reset_state(1, "midreset");
    @(negedge clock);
    reset = 1'b0;
    n = 0;
    repeat (12) begin
      @(posedge clock);
      #1 if (done_o[1]) n++;
    end
    chk("midreset.no_done", 32'(n), 32'd0);
    run_check(1, 0, 32'd0, "after_reset_L1");

    // Randomized checks against the reference model.
    for (int it = 0; it < 24; it++) begin
      g = int'($urandom_range(2, 0));
      mode = int'($urandom_range(3, 0));
      bad_w = int'($urandom_range(31, 0));
      w0[g] = (mode == 1 || mode == 3) ? (EXP_ID ^ (32'd1 << bad_w)) : EXP_ID;
      w1[g] = (mode == 2 || mode == 3) ? (EXP_TS ^ (32'd1 << (31 - bad_w))) : EXP_TS;
      run_check(g, 0, 32'd0, $sformatf("rand%0d_g%0d_m%0d", it, g, mode));
    end

    // Randomized host reads with arbitrary slave contents.
    for (int it = 0; it < 12; it++) begin
      g = int'($urandom_range(2, 0));
      w0[g] = $urandom;
      w1[g] = $urandom;
      host_rd(g, 1'($urandom_range(1, 0)), $sformatf("rhost%0d_g%0d", it, g));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

endmodule
